enc_quad_counter: RTL and testbench
===================================

// Module: enc_quad_counter
// PURPOSE
//   Quadrature (A/B) incremental-encoder decoder with an up/down position counter.
//   Synchronises the asynchronous a/b pins and decodes every valid Gray-code transition (x4 decoding).
//   Drives a wrapping CNT_W-bit position count, direction and error flags to downstream control logic.
// PARAMETERS
//   CNT_W        8   width of cnt; counter wraps modulo 2**CNT_W
//   SYNC_STAGES  2   flip-flop stages in each input synchroniser; minimum 2
//   CNT_INIT     0   value loaded into cnt on reset
//   FILT_CYCLES  4   glitch-filter depth in clocks; used only with ENC_GLITCH_FILTER_EN; minimum 1
// PORTS
//   clk    in   1      single system clock; all state on rising edge
//   rst_n  in   1      asynchronous, active-low reset
//   a      in   1      encoder channel A; asynchronous to clk
//   b      in   1      encoder channel B; asynchronous to clk
//   cnt    out  CNT_W  position count
//   dir    out  1      last valid step direction: 1 = up/right, 0 = down/left
//   err    out  1      one-clock pulse on an illegal transition (both channels changed)
// BEHAVIOUR
//   Reset (rst_n=0, async assert, sync release):
//     - cnt=CNT_INIT, dir=0, err=0.
//     - Synchroniser flops load 0; previous-state register {A,B} loads 2'b00.
//   Synchronisation: a and b each pass through SYNC_STAGES flops, giving As and Bs.
//   Decode: compare state S={As,Bs} with registered previous state P each clock, then P<=S.
//   Up sequence, A leads B (right): 00->10->11->01->00.
//     - Each step: cnt<=cnt+1 and dir<=1.
//   Down sequence, B leads A (left): 00->01->11->10->00.
//     - Each step: cnt<=cnt-1 and dir<=0.
//   S==P: no change; err<=0.
//   Illegal step (00<->11 or 10<->01, both bits changed):
//     - cnt and dir hold; err=1 for exactly one clock.
//     - P still updates to S.
//   Wrap-around: 2**CNT_W-1 +1 -> 0; 0 -1 -> 2**CNT_W-1. No saturation, no overflow flag.
//   Latency: a pin change stable before rising edge k is reflected in cnt/dir/err after edge k+SYNC_STAGES.
//   Max rate: at most one count per clock; inputs must hold each state >= SYNC_STAGES+1 clocks.
//   Reset mid-operation:
//     - Pending transitions are discarded.
//     - After release, P re-acquires the pins from 00.
//     - If the pins are not 00 at release, the first decoded step may count or flag err; this is defined behaviour.
//   All outputs are registered; no combinational path from a/b to any output.
// CONFIGURATION
//   ENC_GLITCH_FILTER_EN defined:
//     - Each synchronised channel feeds a stability filter; the filtered value updates only after the raw value holds FILT_CYCLES consecutive clocks.
//     - Pulses shorter than FILT_CYCLES are ignored.
//     - Latency grows by FILT_CYCLES clocks; the minimum hold per state becomes SYNC_STAGES+FILT_CYCLES+1 clocks.
//   ENC_GLITCH_FILTER_EN undefined:
//     - No filter; FILT_CYCLES is ignored; synchroniser outputs feed the decoder directly.
// TESTING
//   Hold every input state >= 8 clocks; default parameters.
//   1 Reset, then a=b=0 idle 50 clocks -> cnt=0x00, dir=0, err never asserts.
//   2 Ten right cycles (AB 00,10,11,01 repeated) -> cnt=0x28 (40), dir=1, err stays 0.
//   3 Then ten left cycles (AB 00,01,11,10 repeated) -> cnt=0x00, dir=0.
//   4 From cnt=0, one left step 00->01 -> cnt=0xFF; then one right step 01->00 -> cnt=0x00.
//   5 From AB=00, drive AB=11 in one step -> cnt unchanged, err high for exactly 1 clock.
//   6 Assert rst_n mid-sequence with cnt=0x15 -> cnt=0x00 immediately (async), no clock required.
//     With ENC_GLITCH_FILTER_EN: 2-clock pulse on A -> cnt unchanged.

Source files
------------

// File: rtl/enc_quad_counter.sv
// enc_quad_counter: x4 quadrature (A/B) decoder driving a wrapping up/down position counter.
// Optional macro ENC_GLITCH_FILTER_EN inserts a per-channel stability filter after the synchronisers.
module enc_quad_counter #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_INIT    = 0,
  parameter int FILT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic [CNT_W-1:0] cnt,
  output logic             dir,
  output logic             err
);

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_UP   = 2'b01,
    STEP_DOWN = 2'b10,
    STEP_ILL  = 2'b11
  } step_t;

  // Classify a {A,B} transition: Gray-code neighbours count, both-bits-changed is illegal.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] curr);
    step_t step;
    case ({prev, curr})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step = STEP_UP;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step = STEP_DOWN;
      4'b0011, 4'b1100, 4'b1001, 4'b0110: step = STEP_ILL;
      default:                            step = STEP_NONE;
    endcase
    return step;
  endfunction

  logic [SYNC_STAGES-1:0] a_sync_r;
  logic [SYNC_STAGES-1:0] b_sync_r;
  logic                   a_dec_s;
  logic                   b_dec_s;
  logic [1:0]             prev_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   dir_r;
  logic                   dir_nxt_s;
  logic                   err_r;
  logic                   err_nxt_s;
  step_t                  step_s;

  // Input synchronisers for the asynchronous encoder pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_r <= '0;
      b_sync_r <= '0;
    end else begin
      a_sync_r <= {a_sync_r[SYNC_STAGES-2:0], a};
      b_sync_r <= {b_sync_r[SYNC_STAGES-2:0], b};
    end
  end

`ifdef ENC_GLITCH_FILTER_EN
  localparam int FILT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CYCLES - 1);

  logic [1:0]        raw_s;
  logic [1:0]        filt_r;
  logic [FILT_W-1:0] stab_r [2];

  assign raw_s = {a_sync_r[SYNC_STAGES-1], b_sync_r[SYNC_STAGES-1]};

  // Stability filter: a channel follows its raw value only after FILT_CYCLES consecutive differing clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_r    <= 2'b00;
      stab_r[0] <= '0;
      stab_r[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw_s[i] == filt_r[i]) begin
          stab_r[i] <= '0;
        end else if (stab_r[i] == FILT_LAST) begin
          filt_r[i] <= raw_s[i];
          stab_r[i] <= '0;
        end else begin
          stab_r[i] <= stab_r[i] + FILT_W'(1);
        end
      end
    end
  end

  assign a_dec_s = filt_r[1];
  assign b_dec_s = filt_r[0];
`else
  assign a_dec_s = a_sync_r[SYNC_STAGES-1];
  assign b_dec_s = b_sync_r[SYNC_STAGES-1];
`endif

  // Next-state decode; counter and direction hold on idle and illegal steps
  always_comb begin
    cnt_nxt_s = cnt_r;
    dir_nxt_s = dir_r;
    err_nxt_s = 1'b0;
    step_s    = decode_step(prev_r, {a_dec_s, b_dec_s});
    case (step_s)
      STEP_UP: begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
        dir_nxt_s = 1'b1;
      end
      STEP_DOWN: begin
        cnt_nxt_s = cnt_r - CNT_W'(1);
        dir_nxt_s = 1'b0;
      end
      STEP_ILL: begin
        err_nxt_s = 1'b1;
      end
      default: begin
        cnt_nxt_s = cnt_r;
        dir_nxt_s = dir_r;
        err_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered decoder state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 2'b00;
      cnt_r  <= CNT_W'(CNT_INIT);
      dir_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      prev_r <= {a_dec_s, b_dec_s};
      cnt_r  <= cnt_nxt_s;
      dir_r  <= dir_nxt_s;
      err_r  <= err_nxt_s;
    end
  end

  assign cnt = cnt_r;
  assign dir = dir_r;
  assign err = err_r;

endmodule

// File: tb/tb_enc_quad_counter.sv
// Self-checking bench for enc_quad_counter: table-driven step vectors plus reset, latency and filter sequences.
module tb_enc_quad_counter;

  localparam int HOLD = 8;
`ifdef ENC_GLITCH_FILTER_EN
  localparam int LAT = 2 + 4;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic       a;
    logic       b;
    logic [7:0] cnt;
    logic       dir;
    int         errs;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic [7:0] cnt;
  logic       dir;
  logic       err;

  int   checks;
  int   errors;
  int   err_pulses;
  vec_t vecs[$];

  enc_quad_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cnt   (cnt),
    .dir   (dir),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count clocks on which err is high
  always @(negedge clk) begin
    if (err === 1'b1) err_pulses = err_pulses + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic va, input logic vb, input logic [7:0] vcnt,
                         input logic vdir, input int verrs);
    vec_t v;
    v.a    = va;
    v.b    = vb;
    v.cnt  = vcnt;
    v.dir  = vdir;
    v.errs = verrs;
    vecs.push_back(v);
  endtask

  task automatic drive_hold(input logic va, input logic vb, input int n);
    @(posedge clk);
    #1;
    a = va;
    b = vb;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_cnt;
    logic [7:0] base_cnt;

    checks     = 0;
    errors     = 0;
    err_pulses = 0;
    a          = 1'b0;
    b          = 1'b0;
    rst_n      = 1'b0;

    exp_cnt = 8'h00;
    for (int c = 0; c < 10; c++) begin
      exp_cnt = exp_cnt + 8'd1; add_vec(1'b1, 1'b0, exp_cnt, 1'b1, 0);
      exp_cnt = exp_cnt + 8'd1; add_vec(1'b1, 1'b1, exp_cnt, 1'b1, 0);
      exp_cnt = exp_cnt + 8'd1; add_vec(1'b0, 1'b1, exp_cnt, 1'b1, 0);
      exp_cnt = exp_cnt + 8'd1; add_vec(1'b0, 1'b0, exp_cnt, 1'b1, 0);
    end
    for (int c = 0; c < 10; c++) begin
      exp_cnt = exp_cnt - 8'd1; add_vec(1'b0, 1'b1, exp_cnt, 1'b0, 0);
      exp_cnt = exp_cnt - 8'd1; add_vec(1'b1, 1'b1, exp_cnt, 1'b0, 0);
      exp_cnt = exp_cnt - 8'd1; add_vec(1'b1, 1'b0, exp_cnt, 1'b0, 0);
      exp_cnt = exp_cnt - 8'd1; add_vec(1'b0, 1'b0, exp_cnt, 1'b0, 0);
    end
    add_vec(1'b0, 1'b1, 8'hFF, 1'b0, 0);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 0);
    add_vec(1'b1, 1'b1, 8'h00, 1'b1, 1);
    add_vec(1'b0, 1'b1, 8'h01, 1'b1, 0);
    add_vec(1'b0, 1'b0, 8'h02, 1'b1, 0);
    add_vec(1'b1, 1'b0, 8'h03, 1'b1, 0);
    add_vec(1'b0, 1'b1, 8'h03, 1'b1, 1);
    add_vec(1'b0, 1'b0, 8'h04, 1'b1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_cnt", 32'(cnt), 32'h00);
    check("reset_dir", 32'(dir), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    rst_n = 1'b1;

    err_pulses = 0;
    repeat (50) @(posedge clk);
    #1;
    check("idle_cnt", 32'(cnt), 32'h00);
    check("idle_dir", 32'(dir), 32'h0);
    check("idle_err_pulses", 32'(err_pulses), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      a          = vecs[i].a;
      b          = vecs[i].b;
      err_pulses = 0;
      repeat (HOLD) @(posedge clk);
      #1;
      check($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_dir", i), 32'(dir), 32'(vecs[i].dir));
      check($sformatf("vec%0d_err", i), 32'(err_pulses), 32'(vecs[i].errs));
    end

    // Walk 17 right steps from 0x04 to reach 0x15, then reset asynchronously mid-cycle
    for (int s = 0; s < 17; s++) begin
      case (s % 4)
        0:       drive_hold(1'b1, 1'b0, HOLD);
        1:       drive_hold(1'b1, 1'b1, HOLD);
        2:       drive_hold(1'b0, 1'b1, HOLD);
        default: drive_hold(1'b0, 1'b0, HOLD);
      endcase
    end
    check("pre_reset_cnt", 32'(cnt), 32'h15);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_cnt", 32'(cnt), 32'h00);
    check("async_reset_dir", 32'(dir), 32'h0);
    a = 1'b0;
    b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    err_pulses = 0;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_cnt", 32'(cnt), 32'h00);
    check("post_reset_err", 32'(err_pulses), 32'd0);

    // Latency: change set up before edge k shows after edge k+LAT, not earlier
    base_cnt = cnt;
    a = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    check("latency_early_cnt", 32'(cnt), 32'(base_cnt));
    @(posedge clk);
    #1;
    check("latency_cnt", 32'(cnt), 32'(base_cnt + 8'd1));
    check("latency_dir", 32'(dir), 32'h1);
    repeat (HOLD) @(posedge clk);
    #1;

`ifdef ENC_GLITCH_FILTER_EN
    base_cnt   = cnt;
    err_pulses = 0;
    b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_cnt", 32'(cnt), 32'(base_cnt));
    check("glitch_err", 32'(err_pulses), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
